// File: rtl/ppu_oam_scan_pkg.sv
// Shared constants, state encoding and line-buffer entry type for the mode-2 OAM sprite search.
package ppu_oam_scan_pkg;

  localparam int OAM_ENTRIES  = 40;
  localparam int MAX_SPRITES  = 10;
  localparam int OBJ_Y_OFFSET = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_Y = 2'd1,
    SCAN_X = 2'd2,
    FINISH = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] y;
    logic [7:0] x;
  } spr_ent_t;

  // 9-bit compare so Y near 0xFF and ly+16 never wrap into a false hit
  function automatic logic spr_hit(input logic [7:0] ly, input logic [7:0] y, input logic tall);
    logic [8:0] t, h, y9;
    t  = {1'b0, ly} + 9'(OBJ_Y_OFFSET);
    h  = tall ? 9'd16 : 9'd8;
    y9 = {1'b0, y};
    return (t >= y9) && (t < y9 + h);
  endfunction

endpackage

// File: rtl/ppu_oam_scan_if.sv
// OAM read bus shared between the sprite scanner and the OAM RAM / DMA arbiter.
interface ppu_oam_scan_if;
  logic       oam_rd;
  logic [7:0] oam_a;
  logic [7:0] oam_din;
  logic       dma_occupy_oambus;

  modport master (output oam_rd, oam_a, input oam_din, dma_occupy_oambus);
  modport slave  (input oam_rd, oam_a, output oam_din, dma_occupy_oambus);
endinterface

// File: rtl/ppu_oam_scan_sprite_buf.sv
// Per-line sprite buffer: one write port, combinational read mux.
module ppu_sprite_buf
  import ppu_oam_scan_pkg::*;
#(
  parameter int DEPTH = MAX_SPRITES
) (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  spr_ent_t   wdata,
  input  logic [3:0] raddr,
  output spr_ent_t   rdata
);

  spr_ent_t mem [DEPTH];

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    always_ff @(posedge clk)
      if (we && waddr == 4'(s)) mem[s] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int s = 0; s < DEPTH; s++)
      if (raddr == 4'(s)) rdata = mem[s];
  end

endmodule

// File: rtl/ppu_oam_scan.sv
// Mode-2 sprite search: walks OAM Y/X pairs, keeps up to MAX_SPRITES hits in OAM order.
module ppu_oam_scan
  import ppu_oam_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          ly,
  input  logic                obj_size,
  ppu_oam_scan_if.master      oam,
  output logic                busy,
  output logic                done,
  output logic [3:0]          spr_count,
  input  logic [3:0]          rd_sel,
  output logic                rd_valid,
  output logic [5:0]          rd_idx,
  output logic [7:0]          rd_y,
  output logic [7:0]          rd_x
);

  localparam logic [5:0] LAST_ENT = 6'(OAM_ENTRIES - 1);

  scan_state_e state_q, state_d;
  logic [5:0]  ent_q;
  logic [7:0]  ly_q, y_q, byte_in;
  logic        tall_q, capture_x, wr_en;
  logic [5:0]  wr_idx;
  spr_ent_t    rd_ent;

  // a byte fetched while DMA owns the bus reads as 0xFF, which can never match
  assign byte_in = oam.dma_occupy_oambus ? 8'hFF : oam.oam_din;

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d    = state_q;
    oam.oam_rd = 1'b0;
    oam.oam_a  = 8'h00;
    capture_x  = 1'b0;
    case (state_q)
      IDLE: ;
      SCAN_Y: begin
        oam.oam_rd = 1'b1;
        oam.oam_a  = {ent_q, 2'b00};
        capture_x  = (ent_q != 6'd0);
        state_d    = SCAN_X;
      end
      SCAN_X: begin
        oam.oam_rd = 1'b1;
        oam.oam_a  = {ent_q, 2'b01};
        state_d    = (ent_q == LAST_ENT) ? FINISH : SCAN_Y;
      end
      FINISH: begin
        capture_x = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) state_d = SCAN_Y;
  end

  // X arrives one entry late in SCAN_Y; FINISH holds ent_q at the last entry
  assign wr_idx = (state_q == FINISH) ? ent_q : ent_q - 6'd1;
  assign wr_en  = capture_x && !start && (spr_count < 4'(MAX_SPRITES)) &&
                  spr_hit(ly_q, y_q, tall_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      spr_count <= 4'd0;
      ent_q     <= 6'd0;
      ly_q      <= 8'd0;
      tall_q    <= 1'b0;
      y_q       <= 8'hFF;
    end else begin
      done <= (state_q == FINISH) && !start;
      if (start) begin
        ly_q      <= ly;
        tall_q    <= obj_size;
        ent_q     <= 6'd0;
        spr_count <= 4'd0;
      end else begin
        if (state_q == SCAN_X) begin
          y_q <= byte_in;
          if (ent_q != LAST_ENT) ent_q <= ent_q + 6'd1;
        end
        if (wr_en) spr_count <= spr_count + 4'd1;
      end
    end
  end

  assign busy = (state_q != IDLE);

  ppu_sprite_buf #(.DEPTH(MAX_SPRITES)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (spr_count),
    .wdata ('{idx: wr_idx, y: y_q, x: byte_in}),
    .raddr (rd_sel),
    .rdata (rd_ent)
  );

  assign rd_valid = (rd_sel < spr_count);
  assign rd_idx   = rd_ent.idx;
  assign rd_y     = rd_ent.y;
  assign rd_x     = rd_ent.x;

endmodule
